// File: rtl/cla_pkg.sv
// Shared constants and bit-level helpers for the pipelined carry-lookahead adder family.
// Also holds the parameter legality check used at elaboration time.
package cla_pkg;

    localparam int CLA_GROUP_DEFAULT = 4;
    localparam int CLA_GROUP_MIN     = 2;
    localparam int CLA_GROUP_MAX     = 8;

    function automatic logic bit_generate(input logic a, input logic b);
        return a & b;
    endfunction

    function automatic logic bit_propagate(input logic a, input logic b);
        return a ^ b;
    endfunction

    function automatic bit cla_params_legal(input int width, input int group);
        return (group >= CLA_GROUP_MIN) && (group <= CLA_GROUP_MAX) &&
               (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block: every internal carry is a flat sum of
// generate/propagate products, plus group generate/propagate for higher-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;

    for (genvar gi = 0; gi < GROUP; gi++) begin : g_bit
        assign g[gi] = bit_generate(a[gi], b[gi]);
        assign p[gi] = bit_propagate(a[gi], b[gi]);
    end

    // c[i] = ci&p[0..i-1] | OR_j g[j]&p[j+1..i-1]; gg is the same sum at i=GROUP without ci
    always_comb begin
        c  = '0;
        gg = 1'b0;
        t  = 1'b0;
        for (int i = 0; i <= GROUP; i++) begin
            t = ci;
            for (int j = 0; j < i; j++) begin
                t = t & p[j];
            end
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++) begin
                    t = t & p[k];
                end
                c[i] = c[i] | t;
                if (i == GROUP) begin
                    gg = gg | t;
                end
            end
        end
    end

    assign gp = &p;
    assign s  = p ^ c[GROUP-1:0];
    assign co = c[GROUP];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor resolving one lookahead group per stage,
// with skewed operands, deskewed sums and a global-stall valid/ready chain.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    if (!cla_params_legal(WIDTH, GROUP)) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP and GROUP must lie in 2..8");
    end

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < NG; gi++) begin : g_stage
        localparam int LO = gi * GROUP;   // sum bits already resolved upstream
        localparam int UP = WIDTH - LO;   // operand bits still pending at this stage

        logic [UP-1:0]         a_in;
        logic [UP-1:0]         b_in;
        logic                  c_in;
        logic                  v_in;
        logic [LO+GROUP-1:0]   s_next;
        logic [GROUP-1:0]      grp_s;
        logic                  grp_co;
        logic                  grp_gg;
        logic                  grp_gp;
        logic                  unused_grp;
        logic                  v_reg;
        logic                  c_reg;
        logic [LO+GROUP-1:0]   s_reg;

        if (gi == 0) begin : g_head
            // Subtraction is A + ~B + !Ci, so the borrow-in is inverted into a carry-in
            assign a_in   = A;
            assign b_in   = sub ? ~B : B;
            assign c_in   = sub ? ~Ci : Ci;
            assign v_in   = in_valid;
            assign s_next = grp_s;
        end else begin : g_body
            assign a_in   = g_stage[gi-1].g_skew.a_reg;
            assign b_in   = g_stage[gi-1].g_skew.b_reg;
            assign c_in   = g_stage[gi-1].c_reg;
            assign v_in   = g_stage[gi-1].v_reg;
            assign s_next = {grp_s, g_stage[gi-1].s_reg};
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_group (
            .a  (a_in[GROUP-1:0]),
            .b  (b_in[GROUP-1:0]),
            .ci (c_in),
            .s  (grp_s),
            .co (grp_co),
            .gg (grp_gg),
            .gp (grp_gp)
        );

        // Group G/P are only needed by a future two-level lookahead variant
        assign unused_grp = grp_gg ^ grp_gp;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_reg <= 1'b0;
                c_reg <= 1'b0;
                s_reg <= '0;
            end else if (advance) begin
                v_reg <= v_in;
                if (v_in) begin
                    c_reg <= grp_co;
                    s_reg <= s_next;
                end
            end
        end

        if (gi < NG - 1) begin : g_skew
            logic [UP-GROUP-1:0] a_reg;
            logic [UP-GROUP-1:0] b_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (advance && v_in) begin
                    a_reg <= a_in[UP-1:GROUP];
                    b_reg <= b_in[UP-1:GROUP];
                end
            end
        end else begin : g_tail
            logic ovf_reg;

            // a^b^s at the MSB recovers the carry into the MSB
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_reg <= grp_co ^ (a_in[GROUP-1] ^ b_in[GROUP-1] ^ grp_s[GROUP-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[NG-1].v_reg;
    assign S         = g_stage[NG-1].s_reg;
    assign Co        = g_stage[NG-1].c_reg;
    assign ovf       = g_stage[NG-1].g_tail.ovf_reg;

endmodule
